// File: rtl/lb1_fill_ctrl_pkg.sv
// Shared types and frame-geometry helpers for the layer-1 line-buffer fill controller.
package lb1_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } lb1_fill_state_t;

  function automatic int unsigned img_rows(input int unsigned row_w);
    return 32'd1 << row_w;
  endfunction

  function automatic int unsigned img_cols(input int unsigned col_w);
    return 32'd1 << col_w;
  endfunction

  function automatic int unsigned win_per_frame(input int unsigned row_w,
                                                input int unsigned col_w,
                                                input int unsigned k);
    return (img_rows(row_w) - k + 1) * (img_cols(col_w) - k + 1);
  endfunction

endpackage

// File: rtl/lb1_fill_ctrl_addr_cnt.sv
// Raster row/col write-address counter for the layer-1 line buffer.
module lb1_addr_cnt #(
  parameter int ROW_W = 3,
  parameter int COL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_col_o,
  output logic             last_pxl_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign last_col_o = (col_q == '1);
  assign last_pxl_o = last_col_o && (row_q == '1);
  assign row_o      = row_q;
  assign col_o      = col_q;

  // Row wraps naturally to 0 after the last pixel of the frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/lb1_fill_ctrl.sv
// Layer-1 line-buffer fill sequencer: write addressing, window tracking, frame FSM.
// Optional abort input enabled by defining LB1_FILL_CTRL_ABORT_EN.
module lb1_fill_ctrl
  import lb1_fill_ctrl_pkg::*;
#(
  parameter int CNT_ROW_WIDTH    = 3,
  parameter int CNT_COLUMN_WIDTH = 2,
  parameter int KERNEL_SIZE      = 3
) (
  input  logic                        ctrl_clk,
  input  logic                        ctrl_rst_b,
  input  logic                        ctrl_start_i,
`ifdef LB1_FILL_CTRL_ABORT_EN
  input  logic                        ctrl_abort_i,
`endif
  input  logic                        pxl_valid_i,
  output logic                        pxl_ready_o,
  output logic                        lb_wr_en_o,
  output logic [CNT_ROW_WIDTH-1:0]    lb_wr_row_o,
  output logic [CNT_COLUMN_WIDTH-1:0] lb_wr_col_o,
  output logic                        win_valid_o,
  input  logic                        win_ready_i,
  output logic [CNT_ROW_WIDTH-1:0]    win_row_o,
  output logic [CNT_COLUMN_WIDTH-1:0] win_col_o,
  output logic                        busy_o,
  output logic                        frame_done_o
);

  localparam logic [CNT_ROW_WIDTH-1:0]    WIN_ROW_MIN = CNT_ROW_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CNT_COLUMN_WIDTH-1:0] WIN_COL_MIN = CNT_COLUMN_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CNT_ROW_WIDTH-1:0]    FILL_ROW    = CNT_ROW_WIDTH'(KERNEL_SIZE - 2);

  lb1_fill_state_t state_q, state_d;

  logic                        win_valid_q, win_valid_d;
  logic [CNT_ROW_WIDTH-1:0]    win_row_q, win_row_d;
  logic [CNT_COLUMN_WIDTH-1:0] win_col_q, win_col_d;

  logic                        abort;
  logic                        accept;
  logic                        win_stall;
  logic                        win_trig;
  logic                        cnt_clr;
  logic [CNT_ROW_WIDTH-1:0]    cnt_row;
  logic [CNT_COLUMN_WIDTH-1:0] cnt_col;
  logic                        last_col;
  logic                        last_pxl;

`ifdef LB1_FILL_CTRL_ABORT_EN
  assign abort = ctrl_abort_i;
`else
  assign abort = 1'b0;
`endif

  assign win_stall   = win_valid_q && !win_ready_i;
  assign pxl_ready_o = ((state_q == FILL) || (state_q == STREAM)) && !win_stall;
  assign accept      = pxl_valid_i && pxl_ready_o;
  assign cnt_clr     = abort || ((state_q == IDLE) && ctrl_start_i);
  assign win_trig    = accept && (cnt_row >= WIN_ROW_MIN) && (cnt_col >= WIN_COL_MIN);

  lb1_addr_cnt #(
    .ROW_W (CNT_ROW_WIDTH),
    .COL_W (CNT_COLUMN_WIDTH)
  ) u_addr_cnt (
    .clk        (ctrl_clk),
    .rst_n      (ctrl_rst_b),
    .clr_i      (cnt_clr),
    .inc_i      (accept),
    .row_o      (cnt_row),
    .col_o      (cnt_col),
    .last_col_o (last_col),
    .last_pxl_o (last_pxl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ctrl_start_i) state_d = FILL;
      FILL:    if (accept && (cnt_row == FILL_ROW) && last_col) state_d = STREAM;
      STREAM:  if (accept && last_pxl) state_d = FLUSH;
      FLUSH:   if (!win_valid_q || win_ready_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // A new window may load in the same cycle the pending one is consumed.
  always_comb begin
    win_valid_d = win_trig || win_stall;
    win_row_d   = win_trig ? cnt_row : win_row_q;
    win_col_d   = win_trig ? cnt_col : win_col_q;
    if (abort) begin
      win_valid_d = 1'b0;
      win_row_d   = '0;
      win_col_d   = '0;
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst_b) begin
    if (!ctrl_rst_b) begin
      state_q     <= IDLE;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign lb_wr_en_o   = accept;
  assign lb_wr_row_o  = cnt_row;
  assign lb_wr_col_o  = cnt_col;
  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = (state_q == DONE);

endmodule
